// File: rtl/cache_axi_bridge_if.sv
// Signal bundle between cache_top, cache_axi_bridge and the AXI memory port.
// The slave modport is the bridge view; master is the cache/memory environment view.
interface cache_axi_bridge_if #(
  parameter int BYTES_PER_LINE = 64,
  parameter int ADDR_WIDTH     = 32
);
  logic                        rd_req;
  logic [2:0]                  rd_type;
  logic [ADDR_WIDTH-1:0]       rd_addr;
  logic                        rd_rdy;
  logic                        ret_valid;
  logic                        ret_last;
  logic [31:0]                 ret_data;
  logic                        wr_req;
  logic [2:0]                  wr_type;
  logic [ADDR_WIDTH-1:0]       wr_addr;
  logic [3:0]                  wr_wstrb;
  logic [BYTES_PER_LINE*8-1:0] wr_data;
  logic                        wr_rdy;
  logic [3:0]                  arid;
  logic [ADDR_WIDTH-1:0]       araddr;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic                        arvalid;
  logic                        arready;
  logic [3:0]                  rid;
  logic [31:0]                 rdata;
  logic [1:0]                  rresp;
  logic                        rlast;
  logic                        rvalid;
  logic                        rready;
  logic [3:0]                  awid;
  logic [ADDR_WIDTH-1:0]       awaddr;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;
  logic                        awvalid;
  logic                        awready;
  logic [3:0]                  wid;
  logic [31:0]                 wdata;
  logic [3:0]                  wstrb;
  logic                        wlast;
  logic                        wvalid;
  logic                        wready;
  logic [3:0]                  bid;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;

  modport slave (
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, wid, wdata, wstrb, wlast, wvalid, bready
  );

  modport master (
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wid, wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/cache_axi_bridge.sv
// Cache refill/write-back to AXI burst bridge with a one-line write-back buffer.
// CACHE_BRIDGE_LINE_HAZARD_EN: only reads to the buffered line wait for the write-back.
module cache_axi_bridge #(
  parameter int BYTES_PER_LINE = 64,
  parameter int ADDR_WIDTH     = 32
) (
  input logic              clk,
  input logic              resetn,
  cache_axi_bridge_if.slave bus
);
  localparam int WORDS = BYTES_PER_LINE / 4;
  localparam int CNT_W = $clog2(WORDS);
  localparam logic [7:0]       LINE_LEN  = 8'(WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WORDS - 1);
  localparam logic [2:0]       TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_t;

  function automatic logic [2:0] size_of(input logic [2:0] t);
    case (t)
      3'b000:  size_of = 3'b000;
      3'b001:  size_of = 3'b001;
      default: size_of = 3'b010;
    endcase
  endfunction

  rd_state_t             r_rd_state, w_rd_state_nxt;
  wr_state_t             r_wr_state, w_wr_state_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_addr, r_wr_addr;
  logic [2:0]            r_rd_type, r_wr_type;
  logic [3:0]            r_wr_strb;
  logic [31:0]           r_wr_buf [WORDS];
  logic [CNT_W-1:0]      r_wcnt;
  logic w_rd_fire, w_wr_fire, w_wr_rdy, w_hazard;
  logic w_rd_line, w_wr_line, w_w_fire, w_w_last;
  logic w_unused;

  assign w_wr_rdy  = (r_wr_state == W_IDLE);
  assign w_rd_fire = bus.rd_req && bus.rd_rdy;
  assign w_wr_fire = bus.wr_req && w_wr_rdy;
  assign w_rd_line = (r_rd_type == TYPE_LINE);
  assign w_wr_line = (r_wr_type == TYPE_LINE);
  assign w_w_fire  = (r_wr_state == W_DATA) && bus.wready;
  assign w_w_last  = !w_wr_line || (r_wcnt == LAST_IDX);
  assign w_unused  = ^{bus.rid, bus.rresp, bus.bid, bus.bresp};

`ifdef CACHE_BRIDGE_LINE_HAZARD_EN
  function automatic logic same_line(input logic [ADDR_WIDTH-1:0] a, input logic [ADDR_WIDTH-1:0] b);
    same_line = ((a >> $clog2(BYTES_PER_LINE)) == (b >> $clog2(BYTES_PER_LINE)));
  endfunction
  assign w_hazard = ((r_wr_state != W_IDLE) && same_line(bus.rd_addr, r_wr_addr)) ||
                    (w_wr_fire && same_line(bus.rd_addr, bus.wr_addr));
`else
  assign w_hazard = (r_wr_state != W_IDLE) || w_wr_fire;
`endif

  assign bus.rd_rdy    = (r_rd_state == R_IDLE) && !w_hazard;
  assign bus.wr_rdy    = w_wr_rdy;
  assign bus.arid      = 4'd0;
  assign bus.araddr    = r_rd_addr;
  assign bus.arlen     = w_rd_line ? LINE_LEN : 8'd0;
  assign bus.arsize    = size_of(r_rd_type);
  assign bus.arburst   = 2'b01;
  assign bus.arvalid   = (r_rd_state == R_AR);
  assign bus.rready    = (r_rd_state == R_DATA);
  // Return path is a direct pass-through of the R channel, gated outside R_DATA.
  assign bus.ret_valid = (r_rd_state == R_DATA) && bus.rvalid;
  assign bus.ret_last  = (r_rd_state == R_DATA) && bus.rvalid && bus.rlast;
  assign bus.ret_data  = (r_rd_state == R_DATA) ? bus.rdata : 32'h0;
  assign bus.awid      = 4'd1;
  assign bus.awaddr    = r_wr_addr;
  assign bus.awlen     = w_wr_line ? LINE_LEN : 8'd0;
  assign bus.awsize    = size_of(r_wr_type);
  assign bus.awburst   = 2'b01;
  assign bus.awvalid   = (r_wr_state == W_AW);
  assign bus.wid       = 4'd1;
  assign bus.wdata     = r_wr_buf[r_wcnt];
  assign bus.wstrb     = w_wr_line ? 4'hf : r_wr_strb;
  assign bus.wlast     = (r_wr_state == W_DATA) && w_w_last;
  assign bus.wvalid    = (r_wr_state == W_DATA);
  assign bus.bready    = (r_wr_state == W_RESP);

  // Read state register and request capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_state <= R_IDLE;
      r_rd_addr  <= {ADDR_WIDTH{1'b0}};
      r_rd_type  <= 3'b000;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      if (w_rd_fire) begin
        r_rd_addr <= bus.rd_addr;
        r_rd_type <= bus.rd_type;
      end
    end
  end

  // Read next-state logic.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_rd_fire) w_rd_state_nxt = R_AR; else w_rd_state_nxt = R_IDLE;
      R_AR:    if (bus.arready) w_rd_state_nxt = R_DATA; else w_rd_state_nxt = R_AR;
      R_DATA:  if (bus.rvalid && bus.rlast) w_rd_state_nxt = R_IDLE; else w_rd_state_nxt = R_DATA;
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // Write state register; the whole line is copied so the cache can move on at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_state <= W_IDLE;
      r_wr_addr  <= {ADDR_WIDTH{1'b0}};
      r_wr_type  <= 3'b000;
      r_wr_strb  <= 4'h0;
      for (int i = 0; i < WORDS; i++) r_wr_buf[i] <= 32'h0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      if (w_wr_fire) begin
        r_wr_addr <= bus.wr_addr;
        r_wr_type <= bus.wr_type;
        r_wr_strb <= bus.wr_wstrb;
        for (int i = 0; i < WORDS; i++) r_wr_buf[i] <= bus.wr_data[i*32 +: 32];
      end
    end
  end

  // W beat counter, cleared while the address phase is pending.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wcnt <= {CNT_W{1'b0}};
    end else if (r_wr_state == W_AW) begin
      r_wcnt <= {CNT_W{1'b0}};
    end else if (w_w_fire && !w_w_last) begin
      r_wcnt <= r_wcnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_wcnt <= r_wcnt;
    end
  end

  // Write next-state logic.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      W_IDLE:  if (w_wr_fire) w_wr_state_nxt = W_AW; else w_wr_state_nxt = W_IDLE;
      W_AW:    if (bus.awready) w_wr_state_nxt = W_DATA; else w_wr_state_nxt = W_AW;
      W_DATA:  if (w_w_fire && w_w_last) w_wr_state_nxt = W_RESP; else w_wr_state_nxt = W_DATA;
      W_RESP:  if (bus.bvalid) w_wr_state_nxt = W_IDLE; else w_wr_state_nxt = W_RESP;
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// Scenario-driven bench for cache_axi_bridge with a scoreboard queue of expected words.
module tb_cache_axi_bridge;
  localparam int BPL   = 64;
  localparam int AW    = 32;
  localparam int WORDS = BPL / 4;
`ifdef CACHE_BRIDGE_LINE_HAZARD_EN
  localparam logic MAC = 1'b1;
`else
  localparam logic MAC = 1'b0;
`endif

  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  logic [31:0] exp_q [$];

  cache_axi_bridge_if #(.BYTES_PER_LINE(BPL), .ADDR_WIDTH(AW)) bus ();
  cache_axi_bridge #(.BYTES_PER_LINE(BPL), .ADDR_WIDTH(AW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_req = 1'b0; bus.rd_type = 3'b000; bus.rd_addr = 32'h0;
    bus.wr_req = 1'b0; bus.wr_type = 3'b000; bus.wr_addr = 32'h0;
    bus.wr_wstrb = 4'h0; bus.wr_data = '0;
    bus.arready = 1'b0; bus.rid = 4'h0; bus.rdata = 32'h0; bus.rresp = 2'b00;
    bus.rlast = 1'b0; bus.rvalid = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bid = 4'h0; bus.bresp = 2'b00; bus.bvalid = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    tick(); tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    bus.rvalid = 1'b1; bus.rlast = 1'b1; bus.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (bus.arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %0h expected 0", bus.arvalid); end
    checks++; if (bus.awvalid !== 1'b0) begin errors++; $display("FAIL rst_awvalid: got %0h expected 0", bus.awvalid); end
    checks++; if (bus.wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid: got %0h expected 0", bus.wvalid); end
    checks++; if (bus.rready !== 1'b0) begin errors++; $display("FAIL rst_rready: got %0h expected 0", bus.rready); end
    checks++; if (bus.bready !== 1'b0) begin errors++; $display("FAIL rst_bready: got %0h expected 0", bus.bready); end
    checks++; if (bus.ret_valid !== 1'b0) begin errors++; $display("FAIL rst_ret_valid: got %0h expected 0", bus.ret_valid); end
    checks++; if (bus.ret_last !== 1'b0) begin errors++; $display("FAIL rst_ret_last: got %0h expected 0", bus.ret_last); end
    checks++; if (bus.wlast !== 1'b0) begin errors++; $display("FAIL rst_wlast: got %0h expected 0", bus.wlast); end
    checks++; if (bus.ret_data !== 32'h0) begin errors++; $display("FAIL rst_ret_data: got %0h expected 0", bus.ret_data); end
    checks++; if (bus.rd_rdy !== 1'b1) begin errors++; $display("FAIL rst_rd_rdy: got %0h expected 1", bus.rd_rdy); end
    checks++; if (bus.wr_rdy !== 1'b1) begin errors++; $display("FAIL rst_wr_rdy: got %0h expected 1", bus.wr_rdy); end
    tick();
    idle_inputs();
  endtask

  task automatic test_line_read();
    int beats;
    int pulses;
    logic exp_last;
    logic [31:0] exp_d;
    beats = 0; pulses = 0; exp_last = 1'b0;
    bus.rd_req = 1'b1; bus.rd_type = 3'b100; bus.rd_addr = 32'h0000_1000;
    @(negedge clk);
    checks++; if (bus.rd_rdy !== 1'b1) begin errors++; $display("FAIL lr_rd_rdy_idle: got %0h expected 1", bus.rd_rdy); end
    tick();
    bus.rd_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.arvalid !== 1'b1) begin errors++; $display("FAIL lr_arvalid: got %0h expected 1", bus.arvalid); end
    checks++; if (bus.araddr !== 32'h0000_1000) begin errors++; $display("FAIL lr_araddr: got %0h expected 1000", bus.araddr); end
    checks++; if (bus.arlen !== 8'd15) begin errors++; $display("FAIL lr_arlen: got %0d expected 15", bus.arlen); end
    checks++; if (bus.arsize !== 3'd2) begin errors++; $display("FAIL lr_arsize: got %0d expected 2", bus.arsize); end
    checks++; if (bus.arburst !== 2'b01) begin errors++; $display("FAIL lr_arburst: got %0d expected 1", bus.arburst); end
    checks++; if (bus.arid !== 4'd0) begin errors++; $display("FAIL lr_arid: got %0d expected 0", bus.arid); end
    checks++; if (bus.rd_rdy !== 1'b0) begin errors++; $display("FAIL lr_rd_rdy_busy: got %0h expected 0", bus.rd_rdy); end
    tick(); tick();
    @(negedge clk);
    checks++; if (bus.arvalid !== 1'b1) begin errors++; $display("FAIL lr_arvalid_hold: got %0h expected 1", bus.arvalid); end
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    for (int cyc = 0; cyc < 40 && beats < WORDS; cyc++) begin
      if (cyc == 8) begin
        bus.rvalid = 1'b0;
      end else begin
        bus.rvalid = 1'b1; bus.rdata = 32'(beats); bus.rlast = (beats == WORDS - 1);
        exp_last = (beats == WORDS - 1);
        exp_q.push_back(32'(beats));
      end
      @(negedge clk);
      checks++; if (bus.rready !== 1'b1) begin errors++; $display("FAIL lr_rready: got %0h expected 1", bus.rready); end
      checks++; if (bus.ret_valid !== bus.rvalid) begin errors++; $display("FAIL lr_ret_valid: got %0h expected %0h", bus.ret_valid, bus.rvalid); end
      if (bus.ret_valid === 1'b1) begin
        pulses++;
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        checks++; if (bus.ret_data !== exp_d) begin errors++; $display("FAIL lr_ret_data: got %0h expected %0h", bus.ret_data, exp_d); end
        checks++; if (bus.ret_last !== exp_last) begin errors++; $display("FAIL lr_ret_last: got %0h expected %0h", bus.ret_last, exp_last); end
      end
      if (bus.rvalid) beats++;
      tick();
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
    checks++; if (pulses != WORDS) begin errors++; $display("FAIL lr_pulses: got %0d expected %0d", pulses, WORDS); end
    @(negedge clk);
    checks++; if (bus.rd_rdy !== 1'b1) begin errors++; $display("FAIL lr_rd_rdy_after: got %0h expected 1", bus.rd_rdy); end
    checks++; if (bus.rready !== 1'b0) begin errors++; $display("FAIL lr_rready_after: got %0h expected 0", bus.rready); end
    tick();
  endtask

  task automatic test_line_write();
    int beats;
    logic [31:0] exp_d;
    beats = 0;
    bus.wr_req = 1'b1; bus.wr_type = 3'b100; bus.wr_addr = 32'h0000_2000; bus.wr_wstrb = 4'h0;
    for (int i = 0; i < WORDS; i++) begin
      bus.wr_data[i*32 +: 32] = 32'hA0 + 32'(i);
      exp_q.push_back(32'hA0 + 32'(i));
    end
    @(negedge clk);
    checks++; if (bus.wr_rdy !== 1'b1) begin errors++; $display("FAIL lw_wr_rdy_idle: got %0h expected 1", bus.wr_rdy); end
    tick();
    bus.wr_req = 1'b0; bus.wr_data = '0;
    @(negedge clk);
    checks++; if (bus.awvalid !== 1'b1) begin errors++; $display("FAIL lw_awvalid: got %0h expected 1", bus.awvalid); end
    checks++; if (bus.awaddr !== 32'h0000_2000) begin errors++; $display("FAIL lw_awaddr: got %0h expected 2000", bus.awaddr); end
    checks++; if (bus.awlen !== 8'd15) begin errors++; $display("FAIL lw_awlen: got %0d expected 15", bus.awlen); end
    checks++; if (bus.awsize !== 3'd2) begin errors++; $display("FAIL lw_awsize: got %0d expected 2", bus.awsize); end
    checks++; if (bus.awburst !== 2'b01) begin errors++; $display("FAIL lw_awburst: got %0d expected 1", bus.awburst); end
    checks++; if (bus.awid !== 4'd1) begin errors++; $display("FAIL lw_awid: got %0d expected 1", bus.awid); end
    checks++; if (bus.wvalid !== 1'b0) begin errors++; $display("FAIL lw_wvalid_early: got %0h expected 0", bus.wvalid); end
    bus.awready = 1'b1;
    tick();
    bus.awready = 1'b0;
    for (int cyc = 0; cyc < 60 && beats < WORDS; cyc++) begin
      bus.wready = (cyc % 2 == 1);
      @(negedge clk);
      checks++; if (bus.wvalid !== 1'b1) begin errors++; $display("FAIL lw_wvalid: got %0h expected 1", bus.wvalid); end
      checks++; if (bus.wr_rdy !== 1'b0) begin errors++; $display("FAIL lw_wr_rdy_busy: got %0h expected 0", bus.wr_rdy); end
      if (bus.wready) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        checks++; if (bus.wdata !== exp_d) begin errors++; $display("FAIL lw_wdata: got %0h expected %0h", bus.wdata, exp_d); end
        checks++; if (bus.wstrb !== 4'hf) begin errors++; $display("FAIL lw_wstrb: got %0h expected f", bus.wstrb); end
        checks++; if (bus.wlast !== (beats == WORDS - 1)) begin errors++; $display("FAIL lw_wlast: got %0h expected %0h", bus.wlast, (beats == WORDS - 1)); end
        checks++; if (bus.wid !== 4'd1) begin errors++; $display("FAIL lw_wid: got %0d expected 1", bus.wid); end
        beats++;
      end
      tick();
    end
    bus.wready = 1'b0;
    checks++; if (beats != WORDS) begin errors++; $display("FAIL lw_beats: got %0d expected %0d", beats, WORDS); end
    @(negedge clk);
    checks++; if (bus.bready !== 1'b1) begin errors++; $display("FAIL lw_bready: got %0h expected 1", bus.bready); end
    checks++; if (bus.wvalid !== 1'b0) begin errors++; $display("FAIL lw_wvalid_resp: got %0h expected 0", bus.wvalid); end
    tick();
    bus.bvalid = 1'b1;
    @(negedge clk);
    checks++; if (bus.wr_rdy !== 1'b0) begin errors++; $display("FAIL lw_wr_rdy_bvalid: got %0h expected 0", bus.wr_rdy); end
    tick();
    bus.bvalid = 1'b0;
    @(negedge clk);
    checks++; if (bus.wr_rdy !== 1'b1) begin errors++; $display("FAIL lw_wr_rdy_after: got %0h expected 1", bus.wr_rdy); end
    checks++; if (bus.bready !== 1'b0) begin errors++; $display("FAIL lw_bready_after: got %0h expected 0", bus.bready); end
    tick();
  endtask

  task automatic test_word_write();
    logic [31:0] exp_d;
    bus.wr_req = 1'b1; bus.wr_type = 3'b010; bus.wr_addr = 32'h0000_3004; bus.wr_wstrb = 4'b0011;
    bus.wr_data = '1;
    bus.wr_data[31:0] = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    tick();
    bus.wr_req = 1'b0; bus.wr_data = '0; bus.wr_wstrb = 4'h0;
    @(negedge clk);
    checks++; if (bus.awaddr !== 32'h0000_3004) begin errors++; $display("FAIL ww_awaddr: got %0h expected 3004", bus.awaddr); end
    checks++; if (bus.awlen !== 8'd0) begin errors++; $display("FAIL ww_awlen: got %0d expected 0", bus.awlen); end
    checks++; if (bus.awsize !== 3'd2) begin errors++; $display("FAIL ww_awsize: got %0d expected 2", bus.awsize); end
    bus.awready = 1'b1;
    tick();
    bus.awready = 1'b0; bus.wready = 1'b1;
    @(negedge clk);
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    checks++; if (bus.wvalid !== 1'b1) begin errors++; $display("FAIL ww_wvalid: got %0h expected 1", bus.wvalid); end
    checks++; if (bus.wdata !== exp_d) begin errors++; $display("FAIL ww_wdata: got %0h expected %0h", bus.wdata, exp_d); end
    checks++; if (bus.wstrb !== 4'b0011) begin errors++; $display("FAIL ww_wstrb: got %0h expected 3", bus.wstrb); end
    checks++; if (bus.wlast !== 1'b1) begin errors++; $display("FAIL ww_wlast: got %0h expected 1", bus.wlast); end
    tick();
    bus.wready = 1'b0;
    @(negedge clk);
    checks++; if (bus.bready !== 1'b1) begin errors++; $display("FAIL ww_bready: got %0h expected 1", bus.bready); end
    checks++; if (bus.wvalid !== 1'b0) begin errors++; $display("FAIL ww_single_beat: got %0h expected 0", bus.wvalid); end
    bus.bvalid = 1'b1;
    tick();
    bus.bvalid = 1'b0;
    @(negedge clk);
    checks++; if (bus.wr_rdy !== 1'b1) begin errors++; $display("FAIL ww_wr_rdy_after: got %0h expected 1", bus.wr_rdy); end
    tick();
  endtask

  task automatic test_hazard();
    logic [31:0] exp_d;
    bus.wr_req = 1'b1; bus.wr_type = 3'b100; bus.wr_addr = 32'h0000_4000;
    for (int i = 0; i < WORDS; i++) bus.wr_data[i*32 +: 32] = 32'h40 + 32'(i);
    tick();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b1; bus.rd_type = 3'b010; bus.rd_addr = 32'h0000_4000;
    @(negedge clk);
    checks++; if (bus.rd_rdy !== 1'b0) begin errors++; $display("FAIL hz_same_line_aw: got %0h expected 0", bus.rd_rdy); end
    bus.awready = 1'b1;
    tick();
    bus.awready = 1'b0; bus.wready = 1'b1;
    for (int i = 0; i < WORDS; i++) tick();
    bus.wready = 1'b0;
    @(negedge clk);
    checks++; if (bus.bready !== 1'b1) begin errors++; $display("FAIL hz_in_resp: got %0h expected 1", bus.bready); end
    checks++; if (bus.rd_rdy !== 1'b0) begin errors++; $display("FAIL hz_same_line_resp: got %0h expected 0", bus.rd_rdy); end
    tick();
    bus.rd_addr = 32'h0000_5000;
    @(negedge clk);
    checks++; if (bus.rd_rdy !== MAC) begin errors++; $display("FAIL hz_other_line: got %0h expected %0h", bus.rd_rdy, MAC); end
    tick();
    bus.rd_req = 1'b0; bus.bvalid = 1'b1;
    tick();
    bus.bvalid = 1'b0;
`ifndef CACHE_BRIDGE_LINE_HAZARD_EN
    bus.rd_req = 1'b1;
    @(negedge clk);
    checks++; if (bus.rd_rdy !== 1'b1) begin errors++; $display("FAIL hz_after_resp: got %0h expected 1", bus.rd_rdy); end
    tick();
    bus.rd_req = 1'b0;
`endif
    @(negedge clk);
    checks++; if (bus.arvalid !== 1'b1) begin errors++; $display("FAIL hz_arvalid: got %0h expected 1", bus.arvalid); end
    checks++; if (bus.araddr !== 32'h0000_5000) begin errors++; $display("FAIL hz_araddr: got %0h expected 5000", bus.araddr); end
    checks++; if (bus.arlen !== 8'd0) begin errors++; $display("FAIL hz_arlen: got %0d expected 0", bus.arlen); end
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1; bus.rlast = 1'b1; bus.rdata = 32'h0000_5555;
    exp_q.push_back(32'h0000_5555);
    @(negedge clk);
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    checks++; if (bus.ret_data !== exp_d) begin errors++; $display("FAIL hz_ret_data: got %0h expected %0h", bus.ret_data, exp_d); end
    checks++; if (bus.ret_last !== 1'b1) begin errors++; $display("FAIL hz_ret_last: got %0h expected 1", bus.ret_last); end
    tick();
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
    @(negedge clk);
    checks++; if (bus.rd_rdy !== 1'b1) begin errors++; $display("FAIL hz_rd_rdy_end: got %0h expected 1", bus.rd_rdy); end
    tick();
  endtask

  task automatic test_same_cycle();
    bus.wr_req = 1'b1; bus.wr_type = 3'b100; bus.wr_addr = 32'h0000_6000;
    bus.rd_req = 1'b1; bus.rd_type = 3'b010; bus.rd_addr = 32'h0000_7000;
    @(negedge clk);
    checks++; if (bus.wr_rdy !== 1'b1) begin errors++; $display("FAIL sc_wr_rdy: got %0h expected 1", bus.wr_rdy); end
    checks++; if (bus.rd_rdy !== MAC) begin errors++; $display("FAIL sc_rd_rdy: got %0h expected %0h", bus.rd_rdy, MAC); end
    tick();
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.awvalid !== 1'b1) begin errors++; $display("FAIL sc_awvalid: got %0h expected 1", bus.awvalid); end
    checks++; if (bus.arvalid !== MAC) begin errors++; $display("FAIL sc_arvalid: got %0h expected %0h", bus.arvalid, MAC); end
    do_reset();
  endtask

  task automatic test_reset_mid_burst();
    bus.rd_req = 1'b1; bus.rd_type = 3'b100; bus.rd_addr = 32'h0000_8000;
    tick();
    bus.rd_req = 1'b0; bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.rvalid = 1'b1; bus.rdata = 32'(i); bus.rlast = 1'b0;
      tick();
    end
    bus.rvalid = 1'b1; bus.rdata = 32'h4;
    @(negedge clk);
    checks++; if (bus.ret_valid !== 1'b1) begin errors++; $display("FAIL rm_beat5_valid: got %0h expected 1", bus.ret_valid); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (bus.arvalid !== 1'b0) begin errors++; $display("FAIL rm_arvalid: got %0h expected 0", bus.arvalid); end
    checks++; if (bus.rready !== 1'b0) begin errors++; $display("FAIL rm_rready: got %0h expected 0", bus.rready); end
    checks++; if (bus.ret_valid !== 1'b0) begin errors++; $display("FAIL rm_ret_valid: got %0h expected 0", bus.ret_valid); end
    checks++; if (bus.ret_data !== 32'h0) begin errors++; $display("FAIL rm_ret_data: got %0h expected 0", bus.ret_data); end
    bus.rvalid = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (bus.rd_rdy !== 1'b1) begin errors++; $display("FAIL rm_rd_rdy: got %0h expected 1", bus.rd_rdy); end
    checks++; if (bus.wr_rdy !== 1'b1) begin errors++; $display("FAIL rm_wr_rdy: got %0h expected 1", bus.wr_rdy); end
    checks++; if (bus.rready !== 1'b0) begin errors++; $display("FAIL rm_rready_after: got %0h expected 0", bus.rready); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    idle_inputs();
    test_reset();
    test_line_read();
    test_line_write();
    test_word_write();
    test_hazard();
    test_same_cycle();
    test_reset_mid_burst();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
